clk_sample_multi: RTL and testbench

Multi-channel phase-accumulator sample-clock generator for the DSP clocking layer. Each of CHANNELS independent numerically controlled oscillators advances by a programmable frequency word per `clk_in` cycle. Each drives a square sample clock (MSB of offset phase) and a one-cycle wrap tick. Configuration is double-buffered and committed atomically across all channels, and all channels can be phase-aligned by a sync strobe, so frequency and phase changes are glitch-coherent.

---
 rtl/clk_sample_multi_pkg.sv | 20 ++
 rtl/clk_sample_multi_if.sv | 34 +++
 rtl/clk_sample_multi_nco_channel.sv | 122 ++++++++++++
 rtl/clk_sample_multi.sv | 68 ++++++
 tb/tb_clk_sample_multi.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/clk_sample_multi_pkg.sv
// clk_sample_pkg: shared constants for the multi-channel sample-clock generator.
//   - cfg_addr decode values (frequency word, phase offset, enable, reserved)
//   - channel-count and phase-width limits
//   - ch_width(): channel-select width derived from the channel count (min 1)
package clk_sample_pkg;

  localparam logic [1:0] CFG_FRE = 2'd0;
  localparam logic [1:0] CFG_OFF = 2'd1;
  localparam logic [1:0] CFG_EN  = 2'd2;
  localparam logic [1:0] CFG_RSV = 2'd3;

  localparam int CH_LIMIT     = 16;
  localparam int PHASE_W_MIN  = 4;

  // A single channel still needs a one-bit select so the port never vanishes.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_sample_multi_if.sv
// clk_sample_multi_if: configuration bus and sample-clock outputs of the
// multi-channel NCO block.
//   master modport: drives cfg_we/cfg_ch/cfg_addr/cfg_wdata/cfg_commit/sync_in,
//                   observes cfg_pending/clk_sample/tick
//   slave modport : the generator itself (mirror directions)
interface clk_sample_multi_if #(
  parameter int PHASE_WIDTH = 32,
  parameter int CHANNELS    = 4
);
  import clk_sample_pkg::*;

  localparam int CH_W = ch_width(CHANNELS);

  logic                   cfg_we;
  logic [CH_W-1:0]        cfg_ch;
  logic [1:0]             cfg_addr;
  logic [PHASE_WIDTH-1:0] cfg_wdata;
  logic                   cfg_commit;
  logic                   sync_in;
  logic                   cfg_pending;
  logic [CHANNELS-1:0]    clk_sample;
  logic [CHANNELS-1:0]    tick;

  modport master (
    output cfg_we, cfg_ch, cfg_addr, cfg_wdata, cfg_commit, sync_in,
    input  cfg_pending, clk_sample, tick
  );

  modport slave (
    input  cfg_we, cfg_ch, cfg_addr, cfg_wdata, cfg_commit, sync_in,
    output cfg_pending, clk_sample, tick
  );

endinterface

// File: rtl/clk_sample_multi_nco_channel.sv
// nco_channel: one numerically controlled oscillator channel.
//   clk_in/rst_n : clock, asynchronous active-low reset
//   we/addr/wdata: shadow write (already qualified for this channel)
//   commit       : load active registers from shadows (same-cycle write included)
//   sync         : force accumulator to zero, suppress the wrap tick
//   clk_sample   : registered MSB of (acc + offset), one cycle behind acc
//   tick         : registered carry out of the accumulator, coincident with wrapped acc
module nco_channel
  import clk_sample_pkg::*;
#(
  parameter int PHASE_WIDTH = 32
) (
  input  logic                   clk_in,
  input  logic                   rst_n,
  input  logic                   we,
  input  logic [1:0]             addr,
  input  logic [PHASE_WIDTH-1:0] wdata,
  input  logic                   commit,
  input  logic                   sync,
  output logic                   clk_sample,
  output logic                   tick
);

  logic [PHASE_WIDTH-1:0] fre_sh_r;
  logic [PHASE_WIDTH-1:0] off_sh_r;
  logic                   en_sh_r;
  logic [PHASE_WIDTH-1:0] fre_act_r;
  logic [PHASE_WIDTH-1:0] off_act_r;
  logic                   en_act_r;
  logic [PHASE_WIDTH-1:0] acc_r;
  logic                   clk_sample_r;
  logic                   tick_r;

  logic [PHASE_WIDTH-1:0] fre_nxt_s;
  logic [PHASE_WIDTH-1:0] off_nxt_s;
  logic                   en_nxt_s;
  logic [PHASE_WIDTH:0]   sum_s;
  logic [PHASE_WIDTH-1:0] phase_s;

  // Next shadow values; also the commit source so a coincident write is bypassed.
  always_comb begin
    fre_nxt_s = fre_sh_r;
    off_nxt_s = off_sh_r;
    en_nxt_s  = en_sh_r;
    if (we) begin
      case (addr)
        CFG_FRE: fre_nxt_s = wdata;
        CFG_OFF: off_nxt_s = wdata;
        CFG_EN:  en_nxt_s  = wdata[0];
        default: en_nxt_s  = en_sh_r;
      endcase
    end else begin
      en_nxt_s = en_sh_r;
    end
  end

  // Accumulator sum with carry (wrap) and offset phase.
  always_comb begin
    sum_s   = {1'b0, acc_r} + {1'b0, fre_act_r};
    phase_s = acc_r + off_act_r;
  end

  // Shadow register bank.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      fre_sh_r <= {PHASE_WIDTH{1'b0}};
      off_sh_r <= {PHASE_WIDTH{1'b0}};
      en_sh_r  <= 1'b0;
    end else begin
      fre_sh_r <= fre_nxt_s;
      off_sh_r <= off_nxt_s;
      en_sh_r  <= en_nxt_s;
    end
  end

  // Active register bank, loaded only on commit.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      fre_act_r <= {PHASE_WIDTH{1'b0}};
      off_act_r <= {PHASE_WIDTH{1'b0}};
      en_act_r  <= 1'b0;
    end else if (commit) begin
      fre_act_r <= fre_nxt_s;
      off_act_r <= off_nxt_s;
      en_act_r  <= en_nxt_s;
    end else begin
      fre_act_r <= fre_act_r;
      off_act_r <= off_act_r;
      en_act_r  <= en_act_r;
    end
  end

  // Accumulator and wrap tick; sync wins over accumulation and hides the wrap.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      acc_r  <= {PHASE_WIDTH{1'b0}};
      tick_r <= 1'b0;
    end else if (sync) begin
      acc_r  <= {PHASE_WIDTH{1'b0}};
      tick_r <= 1'b0;
    end else if (en_act_r) begin
      acc_r  <= sum_s[PHASE_WIDTH-1:0];
      tick_r <= sum_s[PHASE_WIDTH];
    end else begin
      acc_r  <= acc_r;
      tick_r <= 1'b0;
    end
  end

  // Sample clock register from the offset phase MSB.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      clk_sample_r <= 1'b0;
    end else begin
      clk_sample_r <= phase_s[PHASE_WIDTH-1];
    end
  end

  assign clk_sample = clk_sample_r;
  assign tick       = tick_r;

endmodule

// File: rtl/clk_sample_multi.sv
// clk_sample_multi: multi-channel phase-accumulator sample-clock generator.
//   clk_in : sole clock, rising edge
//   RST_n  : asynchronous active-low reset
//   bus    : clk_sample_multi_if.slave -- config writes/commit/sync in,
//            cfg_pending, clk_sample[CHANNELS], tick[CHANNELS] out
// The top decodes writes to one channel, tracks cfg_pending and broadcasts
// commit/sync so every channel changes at the same edge.
module clk_sample_multi
  import clk_sample_pkg::*;
#(
  parameter int PHASE_WIDTH = 32,
  parameter int CHANNELS    = 4
) (
  input logic                 clk_in,
  input logic                 RST_n,
  clk_sample_multi_if.slave   bus
);

  localparam int CH_W = ch_width(CHANNELS);

  logic                addr_ok_s;
  logic                ch_ok_s;
  logic                wr_valid_s;
  logic [CHANNELS-1:0] clk_sample_s;
  logic [CHANNELS-1:0] tick_s;
  logic                cfg_pending_r;

  // A write is valid only for a real register of an existing channel.
  always_comb begin
    addr_ok_s  = (bus.cfg_addr != CFG_RSV);
    ch_ok_s    = ({1'b0, bus.cfg_ch} < (CH_W + 1)'(CHANNELS));
    wr_valid_s = bus.cfg_we & addr_ok_s & ch_ok_s;
  end

  // Pending flag: commit always clears, even with a coincident write.
  always_ff @(posedge clk_in or negedge RST_n) begin
    if (!RST_n) begin
      cfg_pending_r <= 1'b0;
    end else if (bus.cfg_commit) begin
      cfg_pending_r <= 1'b0;
    end else if (wr_valid_s) begin
      cfg_pending_r <= 1'b1;
    end else begin
      cfg_pending_r <= cfg_pending_r;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    nco_channel #(
      .PHASE_WIDTH (PHASE_WIDTH)
    ) u_nco (
      .clk_in     (clk_in),
      .rst_n      (RST_n),
      .we         (wr_valid_s && (bus.cfg_ch == CH_W'(i))),
      .addr       (bus.cfg_addr),
      .wdata      (bus.cfg_wdata),
      .commit     (bus.cfg_commit),
      .sync       (bus.sync_in),
      .clk_sample (clk_sample_s[i]),
      .tick       (tick_s[i])
    );
  end

  assign bus.cfg_pending = cfg_pending_r;
  assign bus.clk_sample  = clk_sample_s;
  assign bus.tick        = tick_s;

endmodule

// File: tb/tb_clk_sample_multi.sv
// Directed bench for clk_sample_multi with PHASE_WIDTH=8, CHANNELS=4.
module tb_clk_sample_multi;
  import clk_sample_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int checks  = 0;
  int errors  = 0;

  clk_sample_multi_if #(.PHASE_WIDTH(8), .CHANNELS(4)) bus ();

  clk_sample_multi #(.PHASE_WIDTH(8), .CHANNELS(4)) dut (
    .clk_in (clk),
    .RST_n  (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.cfg_we     = 1'b0;
    bus.cfg_ch     = 2'd0;
    bus.cfg_addr   = 2'd0;
    bus.cfg_wdata  = 8'd0;
    bus.cfg_commit = 1'b0;
    bus.sync_in    = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic wr(input logic [1:0] ch, input logic [1:0] addr, input logic [7:0] data);
    bus.cfg_we    = 1'b1;
    bus.cfg_ch    = ch;
    bus.cfg_addr  = addr;
    bus.cfg_wdata = data;
    cycle();
    bus.cfg_we    = 1'b0;
  endtask

  task automatic commit();
    bus.cfg_commit = 1'b1;
    cycle();
    bus.cfg_commit = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.clk_sample !== 4'b0000 || bus.tick !== 4'b0000 || bus.cfg_pending !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: cs=%b tick=%b pend=%b, expected 0000/0000/0", bus.clk_sample, bus.tick, bus.cfg_pending);
    end
    wr(2'd0, CFG_RSV, 8'hFF);
    checks++;
    if (bus.cfg_pending !== 1'b0) begin
      errors++;
      $display("FAIL reserved_addr_pending: got %b expected 0", bus.cfg_pending);
    end
    wr(2'd0, CFG_FRE, 8'd64);
    wr(2'd0, CFG_EN, 8'd1);
    checks++;
    if (bus.cfg_pending !== 1'b1) begin
      errors++;
      $display("FAIL write_sets_pending: got %b expected 1", bus.cfg_pending);
    end
    for (int k = 0; k < 6; k++) begin
      cycle();
      checks++;
      if (bus.clk_sample !== 4'b0000 || bus.tick !== 4'b0000) begin
        errors++;
        $display("FAIL uncommitted_idle[%0d]: cs=%b tick=%b expected 0000/0000", k, bus.clk_sample, bus.tick);
      end
    end
  endtask

  task automatic test_single_channel();
    logic e_cs;
    logic e_tk;
    do_reset();
    wr(2'd0, CFG_FRE, 8'd64);
    wr(2'd0, CFG_EN, 8'd1);
    commit();
    checks++;
    if (bus.cfg_pending !== 1'b0) begin
      errors++;
      $display("FAIL commit_clears_pending: got %b expected 0", bus.cfg_pending);
    end
    for (int k = 1; k <= 8; k++) begin
      cycle();
      e_tk = ((k % 4) == 0);
      e_cs = ((k % 4) == 3) || ((k % 4) == 0);
      checks++;
      if (bus.clk_sample !== {3'b000, e_cs} || bus.tick !== {3'b000, e_tk}) begin
        errors++;
        $display("FAIL single_ch[%0d]: cs=%b tick=%b expected cs=%b tick=%b", k, bus.clk_sample, bus.tick, {3'b000, e_cs}, {3'b000, e_tk});
      end
    end
  endtask

  task automatic test_two_channels();
    logic e_cs;
    logic e_tk;
    do_reset();
    wr(2'd0, CFG_FRE, 8'd64);
    wr(2'd0, CFG_EN, 8'd1);
    wr(2'd1, CFG_FRE, 8'd64);
    wr(2'd1, CFG_OFF, 8'd128);
    wr(2'd1, CFG_EN, 8'd1);
    commit();
    for (int k = 1; k <= 8; k++) begin
      cycle();
      e_tk = ((k % 4) == 0);
      e_cs = ((k % 4) == 3) || ((k % 4) == 0);
      checks++;
      if (bus.clk_sample !== {2'b00, ~e_cs, e_cs} || bus.tick !== {2'b00, e_tk, e_tk}) begin
        errors++;
        $display("FAIL two_ch_inverted[%0d]: cs=%b tick=%b expected cs=%b tick=%b", k, bus.clk_sample, bus.tick, {2'b00, ~e_cs, e_cs}, {2'b00, e_tk, e_tk});
      end
    end
  endtask

  task automatic test_pending();
    logic e_cs;
    logic e_tk;
    do_reset();
    wr(2'd0, CFG_FRE, 8'd64);
    wr(2'd0, CFG_EN, 8'd1);
    commit();
    repeat (4) cycle();
    wr(2'd0, CFG_FRE, 8'd32);
    for (int k = 5; k <= 8; k++) begin
      if (k > 5) cycle();
      e_tk = ((k % 4) == 0);
      e_cs = ((k % 4) == 3) || ((k % 4) == 0);
      checks++;
      if (bus.cfg_pending !== 1'b1 || bus.clk_sample[0] !== e_cs || bus.tick[0] !== e_tk) begin
        errors++;
        $display("FAIL pending_old_freq[%0d]: pend=%b cs=%b tick=%b expected 1/%b/%b", k, bus.cfg_pending, bus.clk_sample[0], bus.tick[0], e_cs, e_tk);
      end
    end
    commit();
    checks++;
    if (bus.cfg_pending !== 1'b0 || bus.clk_sample[0] !== 1'b0 || bus.tick[0] !== 1'b0) begin
      errors++;
      $display("FAIL pending_commit: pend=%b cs=%b tick=%b expected 0/0/0", bus.cfg_pending, bus.clk_sample[0], bus.tick[0]);
    end
    for (int j = 1; j <= 16; j++) begin
      cycle();
      e_tk = ((j % 8) == 6);
      e_cs = ((j % 8) >= 3) && ((j % 8) <= 6);
      checks++;
      if (bus.clk_sample[0] !== e_cs || bus.tick[0] !== e_tk) begin
        errors++;
        $display("FAIL period8[%0d]: cs=%b tick=%b expected %b/%b", j, bus.clk_sample[0], bus.tick[0], e_cs, e_tk);
      end
    end
  endtask

  task automatic test_same_cycle();
    logic e_cs;
    logic e_tk;
    do_reset();
    wr(2'd2, CFG_EN, 8'd1);
    commit();
    for (int k = 0; k < 3; k++) begin
      cycle();
      checks++;
      if (bus.clk_sample[2] !== 1'b0 || bus.tick[2] !== 1'b0) begin
        errors++;
        $display("FAIL zero_freq_static[%0d]: cs=%b tick=%b expected 0/0", k, bus.clk_sample[2], bus.tick[2]);
      end
    end
    bus.cfg_we     = 1'b1;
    bus.cfg_ch     = 2'd2;
    bus.cfg_addr   = CFG_FRE;
    bus.cfg_wdata  = 8'd16;
    bus.cfg_commit = 1'b1;
    cycle();
    bus.cfg_we     = 1'b0;
    bus.cfg_commit = 1'b0;
    checks++;
    if (bus.cfg_pending !== 1'b0) begin
      errors++;
      $display("FAIL same_cycle_pending: got %b expected 0", bus.cfg_pending);
    end
    for (int j = 1; j <= 16; j++) begin
      cycle();
      e_tk = (j == 16);
      e_cs = (j >= 9);
      checks++;
      if (bus.clk_sample[2] !== e_cs || bus.tick[2] !== e_tk) begin
        errors++;
        $display("FAIL bypass_freq16[%0d]: cs=%b tick=%b expected %b/%b", j, bus.clk_sample[2], bus.tick[2], e_cs, e_tk);
      end
    end
  endtask

  task automatic test_sync();
    logic [3:0] e_cs0;
    logic [3:0] e_cs1;
    logic [3:0] e_tk0;
    logic [3:0] e_tk1;
    e_cs0 = 4'b1100;  // bit j-1 holds cycle j
    e_cs1 = 4'b0100;
    e_tk0 = 4'b1000;
    e_tk1 = 4'b0100;
    do_reset();
    wr(2'd0, CFG_FRE, 8'd64);
    wr(2'd0, CFG_EN, 8'd1);
    wr(2'd1, CFG_FRE, 8'd96);
    wr(2'd1, CFG_EN, 8'd1);
    commit();
    repeat (3) cycle();
    checks++;
    if (bus.tick[1:0] !== 2'b10) begin
      errors++;
      $display("FAIL pre_sync_tick: got %b expected 10", bus.tick[1:0]);
    end
    repeat (2) cycle();
    bus.sync_in = 1'b1;
    cycle();
    bus.sync_in = 1'b0;
    checks++;
    if (bus.tick[1:0] !== 2'b00 || bus.clk_sample[1:0] !== 2'b10) begin
      errors++;
      $display("FAIL sync_edge: tick=%b cs=%b expected 00/10", bus.tick[1:0], bus.clk_sample[1:0]);
    end
    for (int j = 1; j <= 4; j++) begin
      cycle();
      checks++;
      if (bus.clk_sample[1:0] !== {e_cs1[j-1], e_cs0[j-1]} || bus.tick[1:0] !== {e_tk1[j-1], e_tk0[j-1]}) begin
        errors++;
        $display("FAIL post_sync[%0d]: cs=%b tick=%b expected %b/%b", j, bus.clk_sample[1:0], bus.tick[1:0], {e_cs1[j-1], e_cs0[j-1]}, {e_tk1[j-1], e_tk0[j-1]});
      end
    end
  endtask

  task automatic test_async_reset();
    logic e_cs;
    logic e_tk;
    do_reset();
    wr(2'd0, CFG_FRE, 8'd64);
    wr(2'd0, CFG_EN, 8'd1);
    commit();
    repeat (3) cycle();
    wr(2'd1, CFG_FRE, 8'd5);
    checks++;
    if (bus.clk_sample[0] !== 1'b1 || bus.tick[0] !== 1'b1 || bus.cfg_pending !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_state: cs=%b tick=%b pend=%b expected 1/1/1", bus.clk_sample[0], bus.tick[0], bus.cfg_pending);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.clk_sample !== 4'b0000 || bus.tick !== 4'b0000 || bus.cfg_pending !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: cs=%b tick=%b pend=%b expected 0000/0000/0", bus.clk_sample, bus.tick, bus.cfg_pending);
    end
    #10;
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cycle();
      checks++;
      if (bus.clk_sample !== 4'b0000 || bus.tick !== 4'b0000 || bus.cfg_pending !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_idle[%0d]: cs=%b tick=%b pend=%b expected 0000/0000/0", k, bus.clk_sample, bus.tick, bus.cfg_pending);
      end
    end
    wr(2'd0, CFG_FRE, 8'd64);
    wr(2'd0, CFG_EN, 8'd1);
    commit();
    for (int k = 1; k <= 4; k++) begin
      cycle();
      e_tk = ((k % 4) == 0);
      e_cs = ((k % 4) == 3) || ((k % 4) == 0);
      checks++;
      if (bus.clk_sample !== {3'b000, e_cs} || bus.tick !== {3'b000, e_tk}) begin
        errors++;
        $display("FAIL restart[%0d]: cs=%b tick=%b expected %b/%b", k, bus.clk_sample, bus.tick, {3'b000, e_cs}, {3'b000, e_tk});
      end
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_channel();
    test_two_channels();
    test_pending();
    test_same_cycle();
    test_sync();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
